// File: rtl/reaction_stats.sv
// Reaction-time statistics: keeps last, best, rolling average (and optionally worst)
// of accepted trials and drives one of them onto the display bus. Option macro: STATS_WORST_EN.
module reaction_stats #(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             count_valid,
  input  logic             sel_next,
  input  logic             clear,
  output logic [WIDTH-1:0] display,
  output logic [1:0]       mode,
  output logic [7:0]       trials,
  output logic             avg_valid,
  output logic             new_best,
  output logic             busy
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_MAX = DEPTH[AVG_LOG2:0];

  typedef enum logic [1:0] {IDLE, LATCH, ACCUM} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    cap, last, best;
  logic [SUM_W-1:0]    sum;
  logic [WIDTH-1:0]    win [DEPTH];
  logic [AVG_LOG2-1:0] wptr;
  logic [AVG_LOG2:0]   fill;
  logic [WIDTH-1:0]    avg_value, display_next;
  logic                accept;
`ifdef STATS_WORST_EN
  logic [WIDTH-1:0]    worst;
`endif

  // A zero count is a false start; anything arriving mid-update is dropped.
  assign accept    = (state == IDLE) && count_valid && (count != '0) && !clear;
  assign avg_valid = (fill == FILL_MAX);
  assign avg_value = WIDTH'(sum >> AVG_LOG2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    state_next = state;
    new_best   = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:    if (accept) state_next = LATCH;
      LATCH: begin
        new_best   = !clear && (cap < best);
        state_next = ACCUM;
      end
      ACCUM:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Statistics datapath, stepped by the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the window buffer is reset like any other register because the running
    // sum subtracts old slots, so they must start at a known zero.
    if (rst) begin
      cap   <= '0;
      last  <= '0;
      best  <= '1;
      sum   <= '0;
      wptr  <= '0;
      fill  <= '0;
      trials <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
`ifdef STATS_WORST_EN
      worst <= '0;
`endif
    end else if (clear) begin
      cap   <= '0;
      last  <= '0;
      best  <= '1;
      sum   <= '0;
      wptr  <= '0;
      fill  <= '0;
      trials <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
`ifdef STATS_WORST_EN
      worst <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (accept) cap <= count;
        LATCH: begin
          last <= cap;
          if (cap < best) best <= cap;
`ifdef STATS_WORST_EN
          if (cap > worst) worst <= cap;
`endif
        end
        ACCUM: begin
          // Oldest sample leaves the sum exactly when its slot is overwritten.
          sum       <= sum - SUM_W'(win[wptr]) + SUM_W'(cap);
          win[wptr] <= cap;
          wptr      <= wptr + 1'b1;
          if (fill != FILL_MAX) fill <= fill + 1'b1;
          if (trials != 8'hFF)  trials <= trials + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Mode survives clear; only reset returns it to LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= 2'd0;
    end else if (sel_next) begin
`ifdef STATS_WORST_EN
      mode <= mode + 2'd1;
`else
      mode <= (mode >= 2'd2) ? 2'd0 : mode + 2'd1;
`endif
    end
  end

  always_comb begin
    display_next = '0;
    unique case (mode)
      2'd0: display_next = last;
      2'd1: display_next = (best == '1) ? '0 : best;
      2'd2: display_next = avg_valid ? avg_value : '0;
`ifdef STATS_WORST_EN
      2'd3: display_next = worst;
`else
      2'd3: display_next = '0;
`endif
      default: display_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) display <= '0;
    else     display <= display_next;
  end

endmodule

// File: tb/tb_reaction_stats.sv
// Directed bench for reaction_stats: table-driven trial vectors plus hand-written
// sequences for false starts, busy drops, clear collisions, saturation and mode wrap.
module tb_reaction_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] count;
  logic        count_valid, sel_next, clear;
  logic [15:0] display;
  logic [1:0]  mode;
  logic [7:0]  trials;
  logic        avg_valid, new_best, busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] count;
    logic [15:0] disp;
    logic [7:0]  trials;
    int          nb;
    logic        av;
  } vec_t;

  vec_t best_vec[3];
  vec_t avg_vec[9];

  reaction_stats #(.WIDTH(16), .AVG_LOG2(3)) dut (
    .clk(clk), .rst(rst), .count(count), .count_valid(count_valid),
    .sel_next(sel_next), .clear(clear), .display(display), .mode(mode),
    .trials(trials), .avg_valid(avg_valid), .new_best(new_best), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic trial(input logic [15:0] c, output int nb);
    @(negedge clk); count = c; count_valid = 1'b1;
    @(negedge clk); count_valid = 1'b0; nb = int'(new_best);
    @(negedge clk); nb += int'(new_best);
    @(negedge clk); nb += int'(new_best);
    @(negedge clk);
  endtask

  task automatic press_sel();
    @(negedge clk); sel_next = 1'b1;
    @(negedge clk); sel_next = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int nb;
    trial(v.count, nb);
    check({tag, " display"}, 32'(display), 32'(v.disp));
    check({tag, " trials"}, 32'(trials), 32'(v.trials));
    check({tag, " new_best"}, 32'(nb), 32'(v.nb));
    check({tag, " avg_valid"}, 32'(avg_valid), 32'(v.av));
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nb;
    best_vec[0] = '{count: 16'd400, disp: 16'd350, trials: 8'd2, nb: 0, av: 1'b0};
    best_vec[1] = '{count: 16'd300, disp: 16'd300, trials: 8'd3, nb: 1, av: 1'b0};
    best_vec[2] = '{count: 16'd300, disp: 16'd300, trials: 8'd4, nb: 0, av: 1'b0};
    for (int i = 0; i < 7; i++)
      avg_vec[i] = '{count: 16'(100 * (i + 1)), disp: 16'd0, trials: 8'(i + 1), nb: 1 - int'(i != 0), av: 1'b0};
    avg_vec[7] = '{count: 16'd800, disp: 16'd450, trials: 8'd8, nb: 0, av: 1'b1};
    avg_vec[8] = '{count: 16'd900, disp: 16'd550, trials: 8'd9, nb: 0, av: 1'b1};

    rst = 1'b1; count = '0; count_valid = 1'b0; sel_next = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset display", 32'(display), 32'd0);
    check("reset mode", 32'(mode), 32'd0);
    check("reset trials", 32'(trials), 32'd0);
    check("reset avg_valid", 32'(avg_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset new_best", 32'(new_best), 32'd0);

    // First trial, LAST mode.
    trial(16'd350, nb);
    check("t350 last", 32'(display), 32'd350);
    check("t350 trials", 32'(trials), 32'd1);
    check("t350 new_best", 32'(nb), 32'd1);
    check("t350 avg_valid", 32'(avg_valid), 32'd0);

    press_sel();
    check("mode best", 32'(mode), 32'd1);
    check("best display", 32'(display), 32'd350);
    for (int i = 0; i < 3; i++) apply_vec($sformatf("best[%0d]", i), best_vec[i]);

    // False start: count==0 is ignored.
    @(negedge clk); count = 16'd0; count_valid = 1'b1;
    @(negedge clk); count_valid = 1'b0;
    check("zero busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("zero trials", 32'(trials), 32'd4);

    // Second count_valid while busy is dropped (100 would otherwise become best).
    @(negedge clk); count = 16'd500; count_valid = 1'b1;
    @(negedge clk); count = 16'd100;
    check("drop busy high", 32'(busy), 32'd1);
    nb = int'(new_best);
    @(negedge clk); count_valid = 1'b0; nb += int'(new_best);
    repeat (4) begin @(negedge clk); nb += int'(new_best); end
    check("drop trials", 32'(trials), 32'd5);
    check("drop best", 32'(display), 32'd300);
    check("drop new_best", 32'(nb), 32'd0);
    check("drop idle", 32'(busy), 32'd0);

    // Clear collides with count_valid: clear wins.
    @(negedge clk); count = 16'd250; count_valid = 1'b1; clear = 1'b1;
    @(negedge clk); count_valid = 1'b0; clear = 1'b0;
    check("clr busy", 32'(busy), 32'd0);
    check("clr trials", 32'(trials), 32'd0);
    check("clr new_best", 32'(new_best), 32'd0);
    @(negedge clk);
    check("clr best shows 0", 32'(display), 32'd0);
    check("clr mode kept", 32'(mode), 32'd1);
    check("clr avg_valid", 32'(avg_valid), 32'd0);
    check("clr still idle", 32'(busy), 32'd0);

    // Rolling average over 100..800, then wrap with 900.
    press_sel();
    check("mode avg", 32'(mode), 32'd2);
    for (int i = 0; i < 9; i++) apply_vec($sformatf("avg[%0d]", i), avg_vec[i]);

    // Trial counter saturates at 255.
    for (int i = 0; i < 246; i++) trial(16'd1000, nb);
    check("sat trials 255", 32'(trials), 32'd255);
    trial(16'd1000, nb);
    check("sat trials hold", 32'(trials), 32'd255);
    check("sat avg", 32'(display), 32'd1000);

`ifdef STATS_WORST_EN
    press_clear();
    trial(16'd200, nb);
    trial(16'd700, nb);
    trial(16'd500, nb);
    press_sel();
    check("mode worst", 32'(mode), 32'd3);
    check("worst display", 32'(display), 32'd700);
    press_sel();
    check("mode wrap", 32'(mode), 32'd0);
    check("wrap last", 32'(display), 32'd500);
`else
    press_sel();
    check("mode wrap", 32'(mode), 32'd0);
    check("wrap last", 32'(display), 32'd1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
